dummy_stream_master: RTL and testbench

Synthesizable AXI-Stream test-pattern source for the partial-flow magic/dummy IP set. It sits directly upstream of the dummy stream slave, or any hls4ml kernel input port, and drives it with counter-pattern frames of programmable length and count. It also counts backpressure stall cycles, so a non-ready sink (slave with SINK_MODE=0) is observable on hardware and in simulation.

---
 rtl/dummy_stream_master.sv | 157 +++++++++++++++
 tb/tb_dummy_stream_master.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dummy_stream_master.sv
// AXI-Stream counter-pattern source: emits num_frames frames of frame_len beats and counts backpressure stalls.
// Latency: first beat is presented the cycle after start is accepted; every output comes straight from a flop.
module dummy_stream_master #(
   parameter int          DATA_WIDTH  = 32,
   parameter int          LEN_WIDTH   = 16,
   parameter int unsigned SEED        = 0,
   parameter int          IDLE_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  frame_len,
   input  logic [LEN_WIDTH-1:0]  num_frames,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           stall_cycles,
   output logic [DATA_WIDTH-1:0] M_AXI_TDATA,
   output logic                  M_AXI_TVALID,
   input  logic                  M_AXI_TREADY,
   output logic                  M_AXI_TLAST
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   localparam logic [DATA_WIDTH-1:0] SEED_V   = DATA_WIDTH'(SEED);
   localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0]  ONE      = LEN_WIDTH'(1);
   localparam logic [31:0]           GAP_INIT = 32'(IDLE_CYCLES);

   state_t                state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  nfr_q, nfr_d;
   logic [LEN_WIDTH-1:0]  beat_q, beat_d;
   logic [LEN_WIDTH-1:0]  frame_q, frame_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [31:0]           gap_q, gap_d;
   logic [31:0]           stall_q, stall_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  hs;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         nfr_q   <= '0;
         beat_q  <= '0;
         frame_q <= '0;
         data_q  <= '0;
         gap_q   <= '0;
         stall_q <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         nfr_q   <= nfr_d;
         beat_q  <= beat_d;
         frame_q <= frame_d;
         data_q  <= data_d;
         gap_q   <= gap_d;
         stall_q <= stall_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      nfr_d   = nfr_q;
      beat_d  = beat_q;
      frame_d = frame_q;
      data_d  = data_q;
      gap_d   = gap_q;
      stall_d = stall_q;
      valid_d = valid_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      hs      = valid_q & M_AXI_TREADY;

      // Saturating stall count; only SEND ever drives valid high.
      if (valid_q && !M_AXI_TREADY && stall_q != 32'hFFFF_FFFF)
         stall_d = stall_q + 32'd1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (frame_len != '0 && num_frames != '0) begin
                  state_d = S_SEND;
                  len_d   = frame_len;
                  nfr_d   = num_frames;
                  beat_d  = '0;
                  frame_d = '0;
                  data_d  = SEED_V;
                  stall_d = '0;
                  valid_d = 1'b1;
                  last_d  = (frame_len == ONE);
                  busy_d  = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_SEND: begin
            if (hs) begin
               data_d = data_q + DATA_ONE;
               if (last_q) begin
                  beat_d  = '0;
                  frame_d = frame_q + ONE;
                  if (frame_q == nfr_q - ONE) begin
                     state_d = S_IDLE;
                     valid_d = 1'b0;
                     last_d  = 1'b0;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else if (GAP_INIT != 32'd0) begin
                     state_d = S_GAP;
                     gap_d   = GAP_INIT;
                     valid_d = 1'b0;
                     last_d  = 1'b0;
                  end else begin
                     last_d = (len_q == ONE);
                  end
               end else begin
                  beat_d = beat_q + ONE;
                  last_d = (beat_q + ONE == len_q - ONE);
               end
            end
         end
         S_GAP: begin
            gap_d = gap_q - 32'd1;
            if (gap_q == 32'd1) begin
               state_d = S_SEND;
               valid_d = 1'b1;
               last_d  = (len_q == ONE);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign stall_cycles = stall_q;
   assign M_AXI_TDATA  = data_q;
   assign M_AXI_TVALID = valid_q;
   assign M_AXI_TLAST  = last_q;

endmodule

// File: tb/tb_dummy_stream_master.sv
// Bench for dummy_stream_master: inst 0 is 32-bit/SEED 0/back-to-back, inst 1 is 8-bit/SEED FE/2 idle cycles.
// Expected beats come from a frame/beat arithmetic model; randomized TREADY exercises the stall path.
module tb_dummy_stream_master;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  start;
   logic [1:0]  tready;
   logic [15:0] frame_len;
   logic [15:0] num_frames;

   logic        busy0, done0, tvalid0, tlast0;
   logic [31:0] stall0, tdata0;
   logic        busy1, done1, tvalid1, tlast1;
   logic [31:0] stall1;
   logic [7:0]  tdata1;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] cap_data[$];
   bit          cap_last[$];
   int          cap_gaps[$];
   int          first_valid, done_cnt, done_cyc, last_hs_cyc, stall_obs, hold_viol, timeout;
   logic [31:0] end_stall;
   logic        end_busy;

   always #5 clk = ~clk;

   dummy_stream_master #(.DATA_WIDTH(32), .LEN_WIDTH(16), .SEED(0), .IDLE_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .start(start[0]), .frame_len(frame_len), .num_frames(num_frames),
      .busy(busy0), .done(done0), .stall_cycles(stall0), .M_AXI_TDATA(tdata0),
      .M_AXI_TVALID(tvalid0), .M_AXI_TREADY(tready[0]), .M_AXI_TLAST(tlast0));

   dummy_stream_master #(.DATA_WIDTH(8), .LEN_WIDTH(16), .SEED(32'hFE), .IDLE_CYCLES(2)) dut1 (
      .clk(clk), .reset(reset), .start(start[1]), .frame_len(frame_len), .num_frames(num_frames),
      .busy(busy1), .done(done1), .stall_cycles(stall1), .M_AXI_TDATA(tdata1),
      .M_AXI_TVALID(tvalid1), .M_AXI_TREADY(tready[1]), .M_AXI_TLAST(tlast1));

   // Reference: beat k of a run carries SEED+k wrapped to the data width; TLAST closes every frame_len beats.
   function automatic logic [31:0] exp_data(input int sel, input int k);
      longint unsigned s = (sel == 0) ? 64'd0 : 64'hFE;
      longint unsigned m = (sel == 0) ? 64'hFFFF_FFFF : 64'hFF;
      return 32'((s + longint'(k)) & m);
   endfunction

   function automatic bit exp_last(input int k, input int len);
      return (k % len) == len - 1;
   endfunction

   task automatic sample(input int sel, output logic v, output logic [31:0] d, output logic l,
                         output logic dn, output logic b, output logic [31:0] st);
      if (sel == 0) begin
         v = tvalid0; d = tdata0; l = tlast0; dn = done0; b = busy0; st = stall0;
      end else begin
         v = tvalid1; d = {24'b0, tdata1}; l = tlast1; dn = done1; b = busy1; st = stall1;
      end
   endtask

   // Pulses start, then records what the stream does until two cycles past done (or a cycle budget).
   // rmode: 0 always ready, 1 not ready for the first stall_n valid cycles, 2 random ready.
   task automatic capture(input int sel, input int len, input int nfr, input int rmode,
                          input int stall_n, input int restart_cyc);
      logic v, l, dn, b, r, pv, pr, pl;
      logic [31:0] d, st, pd;
      int nheld, gcnt;
      bit counting;
      cap_data.delete(); cap_last.delete(); cap_gaps.delete();
      first_valid = -1; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
      stall_obs = 0; hold_viol = 0; timeout = 1; nheld = 0; gcnt = 0; counting = 0;
      pv = 0; pr = 1; pl = 0; pd = '0;
      frame_len = 16'(len); num_frames = 16'(nfr);
      start[sel] = 1'b1;
      @(posedge clk); #1;
      start[sel] = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         sample(sel, v, d, l, dn, b, st);
         if (pv && !pr && (!v || d !== pd || l !== pl)) hold_viol++;
         if (v && first_valid < 0) first_valid = cyc;
         if (dn) begin done_cnt++; done_cyc = cyc; end
         if (counting) begin
            if (v) begin cap_gaps.push_back(gcnt); counting = 0; end
            else gcnt++;
         end
         case (rmode)
            0: r = 1'b1;
            1: begin r = !(v && nheld < stall_n); if (v && !r) nheld++; end
            default: r = ($urandom_range(0, 2) != 0);
         endcase
         tready[sel] = r;
         if (v && !r) stall_obs++;
         if (v && r) begin
            cap_data.push_back(d); cap_last.push_back(l); last_hs_cyc = cyc;
            if (l) begin counting = 1; gcnt = 0; end
         end
         start[sel] = (cyc == restart_cyc);
         if (cyc == restart_cyc) begin frame_len = 16'd7; num_frames = 16'd5; end
         if (done_cnt > 0 && cyc >= done_cyc + 2) begin
            end_stall = st; end_busy = b; timeout = 0;
            break;
         end
         pv = v; pr = r; pl = l; pd = d;
         @(posedge clk); #1;
      end
      start[sel] = 1'b0;
      tready[sel] = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 2'b00; tready = 2'b11; frame_len = '0; num_frames = '0;
      repeat (2) @(posedge clk);
      #1;
      if ({tvalid0, tlast0, busy0, done0} !== 4'b0) begin n_err++; $display("FAIL reset_ctl0 got %b want 0000", {tvalid0, tlast0, busy0, done0}); end
      n_vec++;
      if (tdata0 !== 32'd0 || stall0 !== 32'd0) begin n_err++; $display("FAIL reset_dat0 got data %h stall %h want 0", tdata0, stall0); end
      n_vec++;
      if ({tvalid1, tlast1, busy1, done1} !== 4'b0) begin n_err++; $display("FAIL reset_ctl1 got %b want 0000", {tvalid1, tlast1, busy1, done1}); end
      n_vec++;
      if (tdata1 !== 8'd0 || stall1 !== 32'd0) begin n_err++; $display("FAIL reset_dat1 got data %h stall %h want 0", tdata1, stall1); end
      n_vec++;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_frame;
      capture(0, 4, 1, 0, 0, -1);
      if (timeout != 0 || cap_data.size() != 4) begin n_err++; $display("FAIL single_beats got %0d beats timeout %0d want 4", cap_data.size(), timeout); end
      n_vec++;
      for (int k = 0; k < cap_data.size(); k++) begin
         if (cap_data[k] !== exp_data(0, k) || cap_last[k] !== exp_last(k, 4)) begin
            n_err++; $display("FAIL single_beat%0d got %h/%b want %h/%b", k, cap_data[k], cap_last[k], exp_data(0, k), exp_last(k, 4));
         end
         n_vec++;
      end
      if (first_valid != 0 || last_hs_cyc != 3) begin n_err++; $display("FAIL single_timing got first %0d last %0d want 0 3", first_valid, last_hs_cyc); end
      n_vec++;
      if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin n_err++; $display("FAIL single_done got cnt %0d cyc %0d want 1 %0d", done_cnt, done_cyc, last_hs_cyc + 1); end
      n_vec++;
      if (end_stall !== 32'd0 || end_busy !== 1'b0) begin n_err++; $display("FAIL single_end got stall %0d busy %b want 0 0", end_stall, end_busy); end
      n_vec++;
   endtask

   task automatic test_backpressure;
      capture(0, 4, 1, 1, 10, -1);
      if (timeout != 0 || cap_data.size() != 4) begin n_err++; $display("FAIL bp_beats got %0d want 4", cap_data.size()); end
      n_vec++;
      for (int k = 0; k < cap_data.size(); k++) begin
         if (cap_data[k] !== exp_data(0, k) || cap_last[k] !== exp_last(k, 4)) begin
            n_err++; $display("FAIL bp_beat%0d got %h/%b want %h/%b", k, cap_data[k], cap_last[k], exp_data(0, k), exp_last(k, 4));
         end
         n_vec++;
      end
      if (hold_viol != 0) begin n_err++; $display("FAIL bp_hold got %0d unstable cycles want 0", hold_viol); end
      n_vec++;
      if (end_stall !== 32'd10) begin n_err++; $display("FAIL bp_stall got %0d want 10", end_stall); end
      n_vec++;
      if (done_cnt != 1 || last_hs_cyc != 13) begin n_err++; $display("FAIL bp_done got cnt %0d last_hs %0d want 1 13", done_cnt, last_hs_cyc); end
      n_vec++;
   endtask

   task automatic test_gaps;
      capture(1, 2, 3, 0, 0, -1);
      if (timeout != 0 || cap_data.size() != 6) begin n_err++; $display("FAIL gap_beats got %0d want 6", cap_data.size()); end
      n_vec++;
      for (int k = 0; k < cap_data.size(); k++) begin
         if (cap_data[k] !== exp_data(1, k) || cap_last[k] !== exp_last(k, 2)) begin
            n_err++; $display("FAIL gap_beat%0d got %h/%b want %h/%b", k, cap_data[k], cap_last[k], exp_data(1, k), exp_last(k, 2));
         end
         n_vec++;
      end
      if (cap_gaps.size() != 2) begin n_err++; $display("FAIL gap_count got %0d want 2", cap_gaps.size()); end
      n_vec++;
      foreach (cap_gaps[i]) begin
         if (cap_gaps[i] != 2) begin n_err++; $display("FAIL gap_len%0d got %0d want 2", i, cap_gaps[i]); end
         n_vec++;
      end
      if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin n_err++; $display("FAIL gap_done got cnt %0d cyc %0d want 1 %0d", done_cnt, done_cyc, last_hs_cyc + 1); end
      n_vec++;
   endtask

   task automatic test_zero_len;
      for (int z = 0; z < 2; z++) begin
         capture(z, (z == 0) ? 0 : 3, (z == 0) ? 2 : 0, 0, 0, -1);
         if (first_valid != -1 || cap_data.size() != 0) begin n_err++; $display("FAIL zero%0d_valid got first %0d beats %0d want none", z, first_valid, cap_data.size()); end
         n_vec++;
         if (timeout != 0 || done_cnt != 1 || done_cyc != 0) begin n_err++; $display("FAIL zero%0d_done got cnt %0d cyc %0d want 1 0", z, done_cnt, done_cyc); end
         n_vec++;
         if (end_busy !== 1'b0) begin n_err++; $display("FAIL zero%0d_busy got %b want 0", z, end_busy); end
         n_vec++;
      end
   endtask

   task automatic test_reset_midframe;
      frame_len = 16'd4; num_frames = 16'd1; tready[0] = 1'b1; start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      if (tvalid0 !== 1'b1 || tdata0 !== 32'd2) begin n_err++; $display("FAIL rst_mid_pre got v %b d %h want 1 2", tvalid0, tdata0); end
      n_vec++;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      if ({tvalid0, busy0, done0, tlast0} !== 4'b0) begin n_err++; $display("FAIL rst_mid_post got %b want 0000", {tvalid0, busy0, done0, tlast0}); end
      n_vec++;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (tvalid0 !== 1'b0 || done0 !== 1'b0) begin n_err++; $display("FAIL rst_mid_quiet%0d got v %b done %b want 0 0", c, tvalid0, done0); end
         n_vec++;
      end
      capture(0, 4, 1, 0, 0, -1);
      if (cap_data.size() != 4 || cap_data[0] !== exp_data(0, 0)) begin n_err++; $display("FAIL rst_mid_restart got %0d beats first %h want 4 %h", cap_data.size(), (cap_data.size() > 0) ? cap_data[0] : 32'hx, exp_data(0, 0)); end
      n_vec++;
   endtask

   task automatic test_busy_start;
      // start pulsed during the inter-frame gap with different length/count must be ignored.
      capture(1, 2, 2, 0, 0, 2);
      if (timeout != 0 || cap_data.size() != 4) begin n_err++; $display("FAIL busy_start_beats got %0d want 4", cap_data.size()); end
      n_vec++;
      for (int k = 0; k < cap_data.size(); k++) begin
         if (cap_data[k] !== exp_data(1, k) || cap_last[k] !== exp_last(k, 2)) begin
            n_err++; $display("FAIL busy_start_beat%0d got %h/%b want %h/%b", k, cap_data[k], cap_last[k], exp_data(1, k), exp_last(k, 2));
         end
         n_vec++;
      end
      if (done_cnt != 1) begin n_err++; $display("FAIL busy_start_done got %0d want 1", done_cnt); end
      n_vec++;
   endtask

   task automatic test_wrap;
      logic [31:0] want[4];
      want[0] = 32'hFE; want[1] = 32'hFF; want[2] = 32'h00; want[3] = 32'h01;
      capture(1, 4, 1, 0, 0, -1);
      if (cap_data.size() != 4) begin n_err++; $display("FAIL wrap_beats got %0d want 4", cap_data.size()); end
      n_vec++;
      for (int k = 0; k < 4 && k < cap_data.size(); k++) begin
         if (cap_data[k] !== want[k] || cap_last[k] !== (k == 3)) begin
            n_err++; $display("FAIL wrap_beat%0d got %h/%b want %h/%b", k, cap_data[k], cap_last[k], want[k], (k == 3));
         end
         n_vec++;
      end
   endtask

   task automatic test_back_to_back;
      capture(0, 3, 3, 0, 0, -1);
      if (cap_data.size() != 9 || cap_gaps.size() != 2) begin n_err++; $display("FAIL b2b_shape got %0d beats %0d gaps want 9 2", cap_data.size(), cap_gaps.size()); end
      n_vec++;
      if (last_hs_cyc != 8) begin n_err++; $display("FAIL b2b_cycles got last_hs %0d want 8", last_hs_cyc); end
      n_vec++;
      foreach (cap_gaps[i]) begin
         if (cap_gaps[i] != 0) begin n_err++; $display("FAIL b2b_gap%0d got %0d want 0", i, cap_gaps[i]); end
         n_vec++;
      end
   endtask

   task automatic test_random;
      for (int run = 0; run < 10; run++) begin
         int sel = run % 2;
         int len = $urandom_range(1, 5);
         int nfr = $urandom_range(1, 3);
         int gap = (sel == 0) ? 0 : 2;
         capture(sel, len, nfr, 2, 0, -1);
         if (timeout != 0 || cap_data.size() != len * nfr) begin n_err++; $display("FAIL rnd%0d_beats got %0d want %0d", run, cap_data.size(), len * nfr); end
         n_vec++;
         for (int k = 0; k < cap_data.size(); k++) begin
            if (cap_data[k] !== exp_data(sel, k) || cap_last[k] !== exp_last(k, len)) begin
               n_err++; $display("FAIL rnd%0d_beat%0d got %h/%b want %h/%b", run, k, cap_data[k], cap_last[k], exp_data(sel, k), exp_last(k, len));
            end
            n_vec++;
         end
         if (cap_gaps.size() != nfr - 1) begin n_err++; $display("FAIL rnd%0d_ngaps got %0d want %0d", run, cap_gaps.size(), nfr - 1); end
         n_vec++;
         foreach (cap_gaps[i]) begin
            if (cap_gaps[i] != gap) begin n_err++; $display("FAIL rnd%0d_gap%0d got %0d want %0d", run, i, cap_gaps[i], gap); end
            n_vec++;
         end
         if (hold_viol != 0) begin n_err++; $display("FAIL rnd%0d_hold got %0d want 0", run, hold_viol); end
         n_vec++;
         if (end_stall !== 32'(stall_obs)) begin n_err++; $display("FAIL rnd%0d_stall got %0d want %0d", run, end_stall, stall_obs); end
         n_vec++;
         if (done_cnt != 1 || done_cyc != last_hs_cyc + 1 || end_busy !== 1'b0) begin
            n_err++; $display("FAIL rnd%0d_done got cnt %0d cyc %0d busy %b want 1 %0d 0", run, done_cnt, done_cyc, end_busy, last_hs_cyc + 1);
         end
         n_vec++;
      end
   endtask

   initial begin
      test_reset;
      test_single_frame;
      test_backpressure;
      test_gaps;
      test_zero_len;
      test_reset_midframe;
      test_busy_start;
      test_wrap;
      test_back_to_back;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
